crc_job_sched: RTL and testbench



---
 rtl/crc_job_sched.sv | 212 +++++++++++++++++++++
 tb/tb_crc_job_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : crc_job_sched
// Purpose  : Round-robin job scheduler in front of the CRC core configuration
//            path. Accepts descriptors from NUM_REQ requesters, runs one job
//            at a time (launch, wait for interrupt or watchdog, acknowledge)
//            and returns a status response tagged with the requester id.
// Ports    : bus_clk/bus_rst_n        clock, async active-low reset
//            req_valid/req_ready      per-requester handshake (ready = 1-cycle
//                                     one-hot accept pulse)
//            req_addr_src/dst/len/mode packed per-requester descriptors
//            o_start, o_addr_*, o_data_len, o_crc_mode  core launch interface
//            i_idle, i_intr, i_intr_type, i_veri_result core status
//            o_intr_checked           interrupt acknowledge pulse
//            rsp_valid/rsp_ready, rsp_id/status/veri/cause  response channel
//            busy                     high whenever not IDLE
// Revision : 1.0  initial release
// ============================================================================
module crc_job_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TMO_W   = 20
) (
   input  logic                  bus_clk,
   input  logic                  bus_rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*32-1:0] req_addr_src,
   input  logic [NUM_REQ*32-1:0] req_addr_dst,
   input  logic [NUM_REQ*16-1:0] req_len,
   input  logic [NUM_REQ*3-1:0]  req_mode,
   output logic                  o_start,
   output logic [31:0]           o_addr_src,
   output logic [31:0]           o_addr_dst,
   output logic [15:0]           o_data_len,
   output logic [2:0]            o_crc_mode,
   input  logic                  i_idle,
   input  logic                  i_intr,
   input  logic [5:0]            i_intr_type,
   input  logic [1:0]            i_veri_result,
   output logic                  o_intr_checked,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [1:0]            rsp_status,
   output logic [1:0]            rsp_veri,
   output logic [5:0]            rsp_cause,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_ACK    = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   localparam logic [1:0] C_ST_OK   = 2'b00;
   localparam logic [1:0] C_ST_ERR  = 2'b01;
   localparam logic [1:0] C_ST_TMO  = 2'b10;
   localparam logic [1:0] C_ST_BLEN = 2'b11;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [15:0]        len_q, len_d;
   logic [2:0]         mode_q, mode_d;
   logic [1:0]         status_q, status_d;
   logic [1:0]         veri_q, veri_d;
   logic [5:0]         cause_q, cause_d;
   logic [TMO_W-1:0]   wd_q, wd_d;

   logic               w_found;
   logic [ID_W-1:0]    w_win;
   logic               w_grant;
   logic [TMO_W-1:0]   w_wd_inc;

   // Round-robin search starting just above the last winner.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         int idx;
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_win   = ID_W'(idx);
         end
      end
   end

   assign w_grant   = (state_q == S_IDLE) && i_idle && w_found;
   assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

   // The watchdog fires in the RUN cycle whose incremented count reaches all
   // ones, so RUN lasts 2^TMO_W-1 cycles on a timeout.
   assign w_wd_inc  = wd_q + 1'b1;

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      id_d           = id_q;
      src_d          = src_q;
      dst_d          = dst_q;
      len_d          = len_q;
      mode_d         = mode_q;
      status_d       = status_q;
      veri_d         = veri_q;
      cause_d        = cause_q;
      wd_d           = wd_q;
      o_start        = 1'b0;
      o_intr_checked = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_grant) begin
               ptr_d  = w_win;
               id_d   = w_win;
               src_d  = req_addr_src[32*int'(w_win) +: 32];
               dst_d  = req_addr_dst[32*int'(w_win) +: 32];
               len_d  = req_len[16*int'(w_win) +: 16];
               mode_d = req_mode[3*int'(w_win) +: 3];
               if (req_len[16*int'(w_win) +: 16] == 16'd0) begin
                  // Zero-length job is rejected without touching the core.
                  status_d = C_ST_BLEN;
                  veri_d   = 2'b00;
                  cause_d  = 6'b0;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            o_start = 1'b1;
            wd_d    = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            wd_d = w_wd_inc;
            if (i_intr) begin
               cause_d  = i_intr_type;
               veri_d   = i_veri_result;
               status_d = ((i_intr_type[5:1] == 5'b0) && i_intr_type[0]) ? C_ST_OK : C_ST_ERR;
               state_d  = S_ACK;
            end else if (&w_wd_inc) begin
               status_d = C_ST_TMO;
               veri_d   = 2'b00;
               cause_d  = 6'b0;
               state_d  = S_ACK;
            end
         end
         S_ACK: begin
            // Acknowledge even on timeout so a late interrupt is cleared.
            o_intr_checked = 1'b1;
            state_d        = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= ID_W'(NUM_REQ - 1);
         id_q     <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         mode_q   <= '0;
         status_q <= '0;
         veri_q   <= '0;
         cause_q  <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         status_q <= status_d;
         veri_q   <= veri_d;
         cause_q  <= cause_d;
         wd_q     <= wd_d;
      end
   end

   assign o_addr_src = src_q;
   assign o_addr_dst = dst_q;
   assign o_data_len = len_q;
   assign o_crc_mode = mode_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_id     = id_q;
   assign rsp_status = status_q;
   assign rsp_veri   = veri_q;
   assign rsp_cause  = cause_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_crc_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_job_sched
// Purpose  : Directed self-checking bench for crc_job_sched (TMO_W = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_crc_job_sched;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TMO_W   = 4;

   logic                  bus_clk;
   logic                  bus_rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_addr_src;
   logic [NUM_REQ*32-1:0] req_addr_dst;
   logic [NUM_REQ*16-1:0] req_len;
   logic [NUM_REQ*3-1:0]  req_mode;
   logic                  o_start;
   logic [31:0]           o_addr_src;
   logic [31:0]           o_addr_dst;
   logic [15:0]           o_data_len;
   logic [2:0]            o_crc_mode;
   logic                  i_idle;
   logic                  i_intr;
   logic [5:0]            i_intr_type;
   logic [1:0]            i_veri_result;
   logic                  o_intr_checked;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [1:0]            rsp_status;
   logic [1:0]            rsp_veri;
   logic [5:0]            rsp_cause;
   logic                  busy;

   int n_chk = 0;
   int n_err = 0;

   crc_job_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TMO_W(TMO_W)) dut (
      .bus_clk        (bus_clk),
      .bus_rst_n      (bus_rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr_src   (req_addr_src),
      .req_addr_dst   (req_addr_dst),
      .req_len        (req_len),
      .req_mode       (req_mode),
      .o_start        (o_start),
      .o_addr_src     (o_addr_src),
      .o_addr_dst     (o_addr_dst),
      .o_data_len     (o_data_len),
      .o_crc_mode     (o_crc_mode),
      .i_idle         (i_idle),
      .i_intr         (i_intr),
      .i_intr_type    (i_intr_type),
      .i_veri_result  (i_veri_result),
      .o_intr_checked (o_intr_checked),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_id         (rsp_id),
      .rsp_status     (rsp_status),
      .rsp_veri       (rsp_veri),
      .rsp_cause      (rsp_cause),
      .busy           (busy)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   logic [102:0] w_outs;
   assign w_outs = {req_ready, o_start, o_addr_src, o_addr_dst, o_data_len, o_crc_mode,
                    o_intr_checked, rsp_valid, rsp_id, rsp_status, rsp_veri, rsp_cause, busy};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge bus_clk);
      #2;
   endtask

   task automatic do_job(input string tag, input logic [3:0] exp_rdy, input logic [5:0] itype,
                         input logic [1:0] veri, input logic [1:0] exp_st, input logic [1:0] exp_id);
      int n;
      n = 0;
      #1;
      while (req_ready == 4'b0 && n < 20) begin
         step();
         #1;
         n++;
      end
      chk({tag, " grant"}, 128'(req_ready), 128'(exp_rdy));
      step();
      chk({tag, " start"}, 128'(o_start), 128'd1);
      step();
      i_intr = 1'b1; i_intr_type = itype; i_veri_result = veri;
      step();
      chk({tag, " ack"}, 128'(o_intr_checked), 128'd1);
      i_intr = 1'b0; i_intr_type = 6'b0; i_veri_result = 2'b0;
      step();
      chk({tag, " rsp"}, 128'({rsp_valid, rsp_id, rsp_status, rsp_veri, rsp_cause}),
          128'({1'b1, exp_id, exp_st, veri, itype}));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, " rsp_drop"}, 128'(rsp_valid), 128'd0);
   endtask

   task automatic do_reset();
      bus_rst_n = 1'b0;
      #3;
      chk("reset_outs", 128'(w_outs), 128'd0);
      step();
      bus_rst_n = 1'b1;
   endtask

   int  cnt;
   logic seen;

   initial begin
      bus_rst_n     = 1'b0;
      req_valid     = '0;
      req_addr_src  = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      req_addr_dst  = {32'h0000_8400, 32'h0000_8300, 32'h0000_8200, 32'h0000_8100};
      req_len       = {16'd8, 16'd8, 16'd8, 16'd16};
      req_mode      = {3'b001, 3'b010, 3'b011, 3'b101};
      i_idle        = 1'b1;
      i_intr        = 1'b0;
      i_intr_type   = 6'b0;
      i_veri_result = 2'b0;
      rsp_ready     = 1'b0;

      do_reset();
      step();

      // Single job from requester 0 with detailed descriptor/launch checks.
      req_valid = 4'b0001;
      #1;
      chk("t1 ready", 128'(req_ready), 128'h1);
      step();
      req_valid = 4'b0000;
      chk("t1 launch", 128'({o_start, o_data_len, o_crc_mode, o_addr_src, o_addr_dst, busy}),
          128'({1'b1, 16'd16, 3'b101, 32'h0000_1000, 32'h0000_8100, 1'b1}));
      chk("t1 ready_low", 128'(req_ready), 128'd0);
      step();
      chk("t1 start_low", 128'(o_start), 128'd0);
      i_intr = 1'b1; i_intr_type = 6'b000001; i_veri_result = 2'b01;
      step();
      chk("t1 ack", 128'(o_intr_checked), 128'd1);
      i_intr = 1'b0; i_intr_type = 6'b0; i_veri_result = 2'b10;
      step();
      chk("t1 ack_low", 128'(o_intr_checked), 128'd0);
      for (int k = 0; k < 5; k++) begin
         chk("t1 hold", 128'({rsp_valid, rsp_id, rsp_status, rsp_veri, rsp_cause, busy}),
             128'({1'b1, 2'd0, 2'b00, 2'b01, 6'b000001, 1'b1}));
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      i_veri_result = 2'b00;
      chk("t1 idle", 128'({rsp_valid, busy}), 128'd0);

      // Back-to-back round robin from a fresh pointer.
      do_reset();
      step();
      req_valid = 4'b1111;
      do_job("rr0", 4'b0001, 6'b000001, 2'b00, 2'b00, 2'd0);
      do_job("rr1", 4'b0010, 6'b000001, 2'b01, 2'b00, 2'd1);
      do_job("rr2", 4'b0100, 6'b000001, 2'b10, 2'b00, 2'd2);
      do_job("rr3", 4'b1000, 6'b000001, 2'b11, 2'b00, 2'd3);
      do_job("rr4", 4'b0001, 6'b000001, 2'b00, 2'b00, 2'd0);
      req_valid = 4'b1101;
      do_job("rr5", 4'b0100, 6'b000001, 2'b00, 2'b00, 2'd2);
      do_job("rr6", 4'b1000, 6'b000001, 2'b00, 2'b00, 2'd3);
      do_job("rr7", 4'b0001, 6'b000001, 2'b00, 2'b00, 2'd0);
      do_job("rr8", 4'b0100, 6'b000001, 2'b00, 2'b00, 2'd2);

      // Pointer to 0, then requester 2 with zero length while 3 is pending.
      req_valid = 4'b0001;
      do_job("pre", 4'b0001, 6'b000001, 2'b00, 2'b00, 2'd0);
      req_valid = 4'b1100;
      req_len[47:32] = 16'd0;
      #1;
      chk("blen grant", 128'(req_ready), 128'b0100);
      step();
      req_valid = 4'b1000;
      chk("blen rsp", 128'({o_start, rsp_valid, rsp_id, rsp_status, rsp_veri, rsp_cause}),
          128'({1'b0, 1'b1, 2'd2, 2'b11, 2'b00, 6'b0}));
      chk("blen no_grant", 128'(req_ready), 128'd0);
      step();
      chk("blen hold", 128'({o_start, rsp_valid, req_ready}), 128'({1'b0, 1'b1, 4'b0000}));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      req_len[47:32] = 16'd8;
      do_job("after_blen", 4'b1000, 6'b000001, 2'b01, 2'b00, 2'd3);
      req_valid = 4'b0000;

      // Watchdog timeout: core never interrupts.
      step();
      req_valid = 4'b0001;
      i_intr_type = 6'b111111;
      i_veri_result = 2'b11;
      #1;
      chk("tmo grant", 128'(req_ready), 128'h1);
      step();
      req_valid = 4'b0000;
      chk("tmo start", 128'(o_start), 128'd1);
      step();
      cnt = 0;
      while (o_intr_checked !== 1'b1 && cnt < 40) begin
         cnt++;
         step();
      end
      chk("tmo run_cycles", 128'(cnt), 128'd15);
      chk("tmo ack", 128'(o_intr_checked), 128'd1);
      step();
      chk("tmo rsp", 128'({rsp_valid, rsp_id, rsp_status, rsp_veri, rsp_cause}),
          128'({1'b1, 2'd0, 2'b10, 2'b00, 6'b0}));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      i_intr_type = 6'b0;
      i_veri_result = 2'b00;

      // Error cause reported as core error.
      req_valid = 4'b0010;
      do_job("err", 4'b0010, 6'b000101, 2'b10, 2'b01, 2'd1);
      req_valid = 4'b0000;

      // Core not idle: requests wait.
      step();
      i_idle = 1'b0;
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("notidle", 128'({req_ready, busy}), 128'd0);
         step();
      end
      i_idle = 1'b1;
      #1;
      chk("idle grant", 128'(req_ready), 128'h1);
      step();
      req_valid = 4'b0000;
      step();
      step();
      chk("rst busy_before", 128'(busy), 128'd1);
      #1;
      bus_rst_n = 1'b0;
      #1;
      chk("rst async_outs", 128'(w_outs), 128'd0);
      step();
      step();
      bus_rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      chk("rst no_rsp", 128'(seen), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
